// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and total-length helpers.
// Used by vga_timing_gen and vga_fb_ctrl.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int h_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage 0: h/v counters, raw syncs, active flag and frame-buffer address.
// VGA_TEST_PATTERN_EN adds the colour-bar index and frame-end strobe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int SCALE     = 1,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              reset,
`ifdef VGA_TEST_PATTERN_EN
    output logic [2:0]        bar,
    output logic              frame_end,
`endif
    output logic              hsync_raw,
    output logic              vsync_raw,
    output logic              active_raw,
    output logic              first_raw,
    output logic [ADDR_W-1:0] addr
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SL      = $clog2(SCALE);
    localparam int H_WORDS = H_ACTIVE / SCALE;
    localparam logic HS_ACT = 1'(HSYNC_POL);
    localparam logic VS_ACT = 1'(VSYNC_POL);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              h_last;
    logic              v_last;
    logic              v_step;

    assign h_last = h_cnt == HW'(H_TOTAL - 1);
    assign v_last = v_cnt == VW'(V_TOTAL - 1);
    assign v_step = (v_cnt & VW'(SCALE - 1)) == VW'(SCALE - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            if (h_last && v_last)
                line_base <= '0;
            else if (h_cnt == HW'(H_ACTIVE - 1) &&
                     32'(v_cnt) < V_ACTIVE && v_step)
                line_base <= line_base + ADDR_W'(H_WORDS);
        end
    end

    assign hsync_raw  = (32'(h_cnt) >= H_ACTIVE + H_FP &&
                         32'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC)
                        ? HS_ACT : ~HS_ACT;
    assign vsync_raw  = (32'(v_cnt) >= V_ACTIVE + V_FP &&
                         32'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC)
                        ? VS_ACT : ~VS_ACT;
    assign active_raw = 32'(h_cnt) < H_ACTIVE && 32'(v_cnt) < V_ACTIVE;
    assign first_raw  = h_cnt == '0 && v_cnt == '0;
    assign addr       = line_base + ADDR_W'(h_cnt >> SL);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index tracks h_cnt / (H_ACTIVE/8) without a divider.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    logic [BW-1:0] bar_sub;

    always_ff @(posedge clk) begin
        if (reset || h_last) begin
            bar     <= '0;
            bar_sub <= '0;
        end else if (bar_sub == BW'(BAR_W - 1)) begin
            bar     <= bar + 1'b1;
            bar_sub <= '0;
        end else begin
            bar_sub <= bar_sub + 1'b1;
        end
    end

    assign frame_end = h_last && v_last;
`endif

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA frame-buffer scanner: read stage, aligned delay lines, RGB output.
// VGA_TEST_PATTERN_EN adds i_pattern_en and an 8-bar colour pattern.
module vga_fb_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int SCALE      = 1,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     =
        $clog2((H_ACTIVE / SCALE) * (V_ACTIVE / SCALE))
) (
    input  logic                 clk25MHz,
    input  logic                 reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 i_pattern_en,
`endif
    output logic                 fb_rd_en,
    output logic [ADDR_W-1:0]    fb_rd_addr,
    input  logic [3*COLOR_W-1:0] fb_rd_data,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic                 o_active,
    output logic                 o_frame_start
);

    localparam int PIPE = RD_LATENCY + 2;
    localparam logic HS_IDLE = ~1'(HSYNC_POL);
    localparam logic VS_IDLE = ~1'(VSYNC_POL);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    logic              hsync_raw;
    logic              vsync_raw;
    logic              active_raw;
    logic              first_raw;
    logic [ADDR_W-1:0] addr;
    logic              pat_mode;
    logic              rd_go;
    logic [PIPE-1:0]   hs_d;
    logic [PIPE-1:0]   vs_d;
    logic [PIPE-1:0]   act_d;
    logic [PIPE-1:0]   fs_d;
    pix_t              pix_in;
    pix_t              pix_q;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]        bar;
    logic              frame_end;
    logic [PIPE-2:0]   pat_d;
    logic [2:0]        bar_d [PIPE-1];
`endif

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HSYNC_POL(HSYNC_POL),
        .VSYNC_POL(VSYNC_POL),
        .SCALE    (SCALE),
        .ADDR_W   (ADDR_W)
    ) u_timing (
        .clk       (clk25MHz),
        .reset     (reset),
`ifdef VGA_TEST_PATTERN_EN
        .bar       (bar),
        .frame_end (frame_end),
`endif
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .active_raw(active_raw),
        .first_raw (first_raw),
        .addr      (addr)
    );

`ifdef VGA_TEST_PATTERN_EN
    // Mode changes only at the frame boundary so a frame is never mixed.
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            pat_mode <= 1'b0;
            pat_d    <= '0;
            for (int i = 0; i < PIPE - 1; i++)
                bar_d[i] <= '0;
        end else begin
            if (frame_end)
                pat_mode <= i_pattern_en;
            pat_d    <= {pat_d, pat_mode};
            bar_d[0] <= bar;
            for (int i = 1; i < PIPE - 1; i++)
                bar_d[i] <= bar_d[i-1];
        end
    end
`else
    assign pat_mode = 1'b0;
`endif

    assign rd_go  = active_raw && !pat_mode;
    assign pix_in = fb_rd_data;

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
            hs_d       <= {PIPE{HS_IDLE}};
            vs_d       <= {PIPE{VS_IDLE}};
            act_d      <= '0;
            fs_d       <= '0;
        end else begin
            fb_rd_en <= rd_go;
            if (rd_go)
                fb_rd_addr <= addr;
            hs_d  <= {hs_d[PIPE-2:0], hsync_raw};
            vs_d  <= {vs_d[PIPE-2:0], vsync_raw};
            act_d <= {act_d[PIPE-2:0], active_raw};
            fs_d  <= {fs_d[PIPE-2:0], first_raw};
        end
    end

    // Read data lands alongside act_d[PIPE-2]; blanking forces black.
    always_ff @(posedge clk25MHz) begin
        if (reset || !act_d[PIPE-2]) begin
            pix_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
        end else if (pat_d[PIPE-2]) begin
            pix_q.r <= {COLOR_W{bar_d[PIPE-2][2]}};
            pix_q.g <= {COLOR_W{bar_d[PIPE-2][1]}};
            pix_q.b <= {COLOR_W{bar_d[PIPE-2][0]}};
`endif
        end else begin
            pix_q <= pix_in;
        end
    end

    assign o_hsync       = hs_d[PIPE-1];
    assign o_vsync       = vs_d[PIPE-1];
    assign o_active      = act_d[PIPE-1];
    assign o_frame_start = fs_d[PIPE-1];
    assign o_red         = pix_q.r;
    assign o_green       = pix_q.g;
    assign o_blue        = pix_q.b;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Scoreboard bench for vga_fb_ctrl: two small-timing instances,
// SCALE=2/RD_LATENCY=1 with address-derived data, SCALE=1/RD_LATENCY=2.
module tb_vga_fb_ctrl;
    import vga_pkg::*;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int PIPE_A = 3;
    localparam int PIPE_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a, en_b;
    logic [2:0]  addr_a;
    logic [4:0]  addr_b;
    logic [11:0] ram_a, ram_b1, ram_b2;
    logic        hs_a, vs_a, act_a, fs_a;
    logic        hs_b, vs_b, act_b, fs_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int n_checks = 0;
    int n_errors = 0;

    always #20 clk = ~clk;

    vga_fb_ctrl #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .SCALE(2),
        .COLOR_W(4), .RD_LATENCY(1)
    ) dut_a (
        .clk25MHz     (clk),
        .reset        (rst),
`ifdef VGA_TEST_PATTERN_EN
        .i_pattern_en (1'b0),
`endif
        .fb_rd_en     (en_a),
        .fb_rd_addr   (addr_a),
        .fb_rd_data   (ram_a),
        .o_hsync      (hs_a),
        .o_vsync      (vs_a),
        .o_red        (r_a),
        .o_green      (g_a),
        .o_blue       (b_a),
        .o_active     (act_a),
        .o_frame_start(fs_a)
    );

    vga_fb_ctrl #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .SCALE(1),
        .COLOR_W(4), .RD_LATENCY(2)
    ) dut_b (
        .clk25MHz     (clk),
        .reset        (rst),
`ifdef VGA_TEST_PATTERN_EN
        .i_pattern_en (1'b0),
`endif
        .fb_rd_en     (en_b),
        .fb_rd_addr   (addr_b),
        .fb_rd_data   (ram_b2),
        .o_hsync      (hs_b),
        .o_vsync      (vs_b),
        .o_red        (r_b),
        .o_green      (g_b),
        .o_blue       (b_b),
        .o_active     (act_b),
        .o_frame_start(fs_b)
    );

    function automatic logic [11:0] ram_f(int a);
        return 12'((a * 291 + 5) & 12'hfff);
    endfunction

    always @(posedge clk) begin
        ram_a  <= ram_f(int'(addr_a));
        ram_b1 <= 12'hfff;
        ram_b2 <= ram_b1;
    end

    function automatic logic is_act(int h, int v);
        return h < HA && v < VA;
    endfunction

    function automatic int addr_of(int h, int v, int sc);
        return (v / sc) * (HA / sc) + h / sc;
    endfunction

    function automatic logic [15:0] idle_vec(logic hpol);
        return {~hpol, 1'b1, 14'h0};
    endfunction

    function automatic logic [15:0] exp_vec(int h, int v, int sc,
                                            logic hpol, logic ones);
        logic hs, vs, act, fs;
        rgb_t c;
        hs  = (h >= 10 && h < 12) ? hpol : ~hpol;
        vs  = (v == 5) ? 1'b0 : 1'b1;
        act = is_act(h, v);
        fs  = h == 0 && v == 0;
        c   = '0;
        if (act)
            c = ones ? 12'hfff : ram_f(addr_of(h, v, sc));
        return {hs, vs, act, fs, c};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    initial begin
        int  mh, mv, frames, since_rel, max_a, max_b, ea_addr, eb_addr;
        logic ea_en, eb_en, lat_a, lat_b, mid_done;
        mh = 0; mv = 0; frames = 0; since_rel = 0;
        max_a = 0; max_b = 0; ea_addr = 0; eb_addr = 0;
        ea_en = 0; eb_en = 0; lat_a = 0; lat_b = 0; mid_done = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                q_a.delete();
                q_b.delete();
                repeat (PIPE_A) q_a.push_back(idle_vec(1'b0));
                repeat (PIPE_B) q_b.push_back(idle_vec(1'b1));
                mh = 0; mv = 0;
                ea_en = 0; eb_en = 0; ea_addr = 0; eb_addr = 0;
                since_rel = 0; lat_a = 0; lat_b = 0;
            end else begin
                since_rel++;
            end

            check("a_rd_en", 32'(en_a), 32'(ea_en));
            check("a_rd_addr", 32'(addr_a), ea_addr);
            check("b_rd_en", 32'(en_b), 32'(eb_en));
            check("b_rd_addr", 32'(addr_b), eb_addr);
            if (en_a === 1'b1 && int'(addr_a) > max_a) max_a = int'(addr_a);
            if (en_b === 1'b1 && int'(addr_b) > max_b) max_b = int'(addr_b);

            q_a.push_back(exp_vec(mh, mv, 2, 1'b0, 1'b0));
            q_b.push_back(exp_vec(mh, mv, 1, 1'b1, 1'b1));
            check("a_out", {hs_a, vs_a, act_a, fs_a, r_a, g_a, b_a},
                  q_a.pop_front());
            check("b_out", {hs_b, vs_b, act_b, fs_b, r_b, g_b, b_b},
                  q_b.pop_front());

            if (!rst && fs_a === 1'b1 && !lat_a) begin
                check("a_fs_latency", since_rel, PIPE_A);
                lat_a = 1;
            end
            if (!rst && fs_b === 1'b1 && !lat_b) begin
                check("b_fs_latency", since_rel, PIPE_B);
                lat_b = 1;
            end

            ea_en = is_act(mh, mv);
            eb_en = ea_en;
            if (ea_en) begin
                ea_addr = addr_of(mh, mv, 2);
                eb_addr = addr_of(mh, mv, 1);
            end

            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    frames++;
                end
            end

            rst = 1'b0;
            if (cyc < 2) rst = 1'b1;
            if (frames == 1 && mh == 5 && mv == 2 && !mid_done) begin
                rst = 1'b1;
                mid_done = 1;
            end
        end
        check("a_max_addr", max_a, 7);
        check("b_max_addr", max_b, 31);
        check("mid_reset_done", 32'(mid_done), 1);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
